// File: rtl/wt_mem_arbiter.sv
// Memory-side request arbiter for the write-through cache subsystem: shares one
// request channel between the I$ and D$ miss paths, tracks outstanding transactions,
// routes returns, and supports a drain mode.
module wt_mem_arbiter #(
    parameter int unsigned IcWidth        = 128,
    parameter int unsigned DcWidth        = 192,
    parameter int unsigned RtrnWidth      = 256,
    parameter int unsigned MaxOutstanding = 8,
    localparam int unsigned PW = (IcWidth > DcWidth) ? IcWidth : DcWidth,
    localparam int unsigned CW = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 icache_req_i,
    input  logic [IcWidth-1:0]   icache_data_i,
    output logic                 icache_ack_o,
    input  logic                 dcache_req_i,
    input  logic [DcWidth-1:0]   dcache_data_i,
    output logic                 dcache_ack_o,
    output logic                 mem_req_o,
    output logic                 mem_src_o,
    output logic [PW-1:0]        mem_data_o,
    input  logic                 mem_ack_i,
    input  logic                 mem_rtrn_vld_i,
    input  logic                 mem_rtrn_src_i,
    input  logic [RtrnWidth-1:0] mem_rtrn_data_i,
    output logic                 icache_rtrn_vld_o,
    output logic                 dcache_rtrn_vld_o,
    output logic [RtrnWidth-1:0] rtrn_data_o,
    input  logic                 drain_i,
    output logic                 drain_done_o,
    output logic [CW-1:0]        ic_cnt_o,
    output logic [CW-1:0]        dc_cnt_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {IDLE, GNT_IC, GNT_DC} state_e;

    localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

    state_e        state_q, state_d;
    logic          last_q, last_d;      // 1: D$ was granted most recently
    logic [CW-1:0] ic_cnt_q, ic_cnt_d;
    logic [CW-1:0] dc_cnt_q, dc_cnt_d;
    logic          err_q, err_d;

    logic ic_elig, dc_elig;
    logic ic_acc, dc_acc;
    logic ic_ret, dc_ret;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        ic_cnt_d   = ic_cnt_q;
        dc_cnt_d   = dc_cnt_q;
        err_d      = err_q;
        mem_req_o  = 1'b0;
        mem_src_o  = 1'b0;
        mem_data_o = '0;
        ic_acc     = 1'b0;
        dc_acc     = 1'b0;

        ic_elig = icache_req_i && (ic_cnt_q < MaxCnt) && !drain_i;
        dc_elig = dcache_req_i && (dc_cnt_q < MaxCnt) && !drain_i;
        ic_ret  = mem_rtrn_vld_i && !mem_rtrn_src_i;
        dc_ret  = mem_rtrn_vld_i &&  mem_rtrn_src_i;

        case (state_q)
            IDLE: begin
                if (ic_elig && (!dc_elig || last_q)) state_d = GNT_IC;
                else if (dc_elig)                    state_d = GNT_DC;
            end
            GNT_IC: begin
                mem_req_o  = 1'b1;
                mem_data_o = PW'(icache_data_i);
                ic_acc     = mem_ack_i;
                if (mem_ack_i) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            GNT_DC: begin
                mem_req_o  = 1'b1;
                mem_src_o  = 1'b1;
                mem_data_o = PW'(dcache_data_i);
                dc_acc     = mem_ack_i;
                if (mem_ack_i) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A return against an empty count is flagged and never wraps the counter.
        if (ic_ret && ic_cnt_q == '0) err_d = 1'b1;
        if (dc_ret && dc_cnt_q == '0) err_d = 1'b1;

        if (ic_acc && !ic_ret)                         ic_cnt_d = ic_cnt_q + CW'(1);
        else if (!ic_acc && ic_ret && ic_cnt_q != '0)  ic_cnt_d = ic_cnt_q - CW'(1);

        if (dc_acc && !dc_ret)                         dc_cnt_d = dc_cnt_q + CW'(1);
        else if (!dc_acc && dc_ret && dc_cnt_q != '0)  dc_cnt_d = dc_cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            ic_cnt_q <= '0;
            dc_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            ic_cnt_q <= ic_cnt_d;
            dc_cnt_q <= dc_cnt_d;
            err_q    <= err_d;
        end
    end

    assign icache_ack_o      = ic_acc;
    assign dcache_ack_o      = dc_acc;
    assign icache_rtrn_vld_o = ic_ret;
    assign dcache_rtrn_vld_o = dc_ret;
    assign rtrn_data_o       = mem_rtrn_data_i;
    assign drain_done_o      = drain_i && (state_q == IDLE) && (ic_cnt_q == '0) && (dc_cnt_q == '0);
    assign ic_cnt_o          = ic_cnt_q;
    assign dc_cnt_o          = dc_cnt_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Bench for wt_mem_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model.
module tb_wt_mem_arbiter;

    localparam int IC   = 128;
    localparam int DC   = 192;
    localparam int RW   = 256;
    localparam int MAXO = 8;
    localparam int PW   = 192;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          icache_req_i, dcache_req_i;
    logic [IC-1:0] icache_data_i;
    logic [DC-1:0] dcache_data_i;
    logic          icache_ack_o, dcache_ack_o;
    logic          mem_req_o, mem_src_o;
    logic [PW-1:0] mem_data_o;
    logic          mem_ack_i, mem_rtrn_vld_i, mem_rtrn_src_i;
    logic [RW-1:0] mem_rtrn_data_i, rtrn_data_o;
    logic          icache_rtrn_vld_o, dcache_rtrn_vld_o;
    logic          drain_i, drain_done_o, err_o;
    logic [CW-1:0] ic_cnt_o, dc_cnt_o;

    wt_mem_arbiter #(.IcWidth(IC), .DcWidth(DC), .RtrnWidth(RW), .MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .icache_req_i(icache_req_i), .icache_data_i(icache_data_i), .icache_ack_o(icache_ack_o),
        .dcache_req_i(dcache_req_i), .dcache_data_i(dcache_data_i), .dcache_ack_o(dcache_ack_o),
        .mem_req_o(mem_req_o), .mem_src_o(mem_src_o), .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i),
        .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_src_i(mem_rtrn_src_i), .mem_rtrn_data_i(mem_rtrn_data_i),
        .icache_rtrn_vld_o(icache_rtrn_vld_o), .dcache_rtrn_vld_o(dcache_rtrn_vld_o), .rtrn_data_o(rtrn_data_o),
        .drain_i(drain_i), .drain_done_o(drain_done_o),
        .ic_cnt_o(ic_cnt_o), .dc_cnt_o(dc_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] rnd();
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Transaction-level model: who holds the channel (0 none, 1 I$, 2 D$),
    // how many transactions each side has in flight, and who won last.
    int m_owner = 0, m_ic = 0, m_dc = 0;
    bit m_last_dc = 1'b1, m_err = 1'b0;
    bit chk_en = 1'b0;
    bit e_ic_ack = 1'b0, e_dc_ack = 1'b0;

    always @(negedge clk) begin
        logic [PW-1:0] ed;
        bit ic_acc, dc_acc, ic_el, dc_el;
        int ir, dr;
        ed = '0;
        if (m_owner == 1)      ed = PW'(icache_data_i);
        else if (m_owner == 2) ed = PW'(dcache_data_i);
        ic_acc = (m_owner == 1) && mem_ack_i;
        dc_acc = (m_owner == 2) && mem_ack_i;
        ir = (mem_rtrn_vld_i && !mem_rtrn_src_i) ? 1 : 0;
        dr = (mem_rtrn_vld_i &&  mem_rtrn_src_i) ? 1 : 0;
        if (chk_en) begin
            chk("mem_req",     mem_req_o, m_owner != 0);
            chk("mem_src",     mem_src_o, m_owner == 2);
            chk("mem_data",    mem_data_o, ed);
            chk("ic_ack",      icache_ack_o, ic_acc);
            chk("dc_ack",      dcache_ack_o, dc_acc);
            chk("ic_rtrn_vld", icache_rtrn_vld_o, ir == 1);
            chk("dc_rtrn_vld", dcache_rtrn_vld_o, dr == 1);
            chk("rtrn_data",   rtrn_data_o, mem_rtrn_data_i);
            chk("drain_done",  drain_done_o, drain_i && m_owner == 0 && m_ic == 0 && m_dc == 0);
            chk("ic_cnt",      ic_cnt_o, m_ic);
            chk("dc_cnt",      dc_cnt_o, m_dc);
            chk("err",         err_o, m_err);
        end
        e_ic_ack = ic_acc;
        e_dc_ack = dc_acc;
        if (rst_i) begin
            m_owner = 0; m_ic = 0; m_dc = 0; m_last_dc = 1'b1; m_err = 1'b0;
        end else begin
            ic_el = icache_req_i && m_ic < MAXO && !drain_i;
            dc_el = dcache_req_i && m_dc < MAXO && !drain_i;
            if ((ir == 1 && m_ic == 0) || (dr == 1 && m_dc == 0)) m_err = 1'b1;
            m_ic = m_ic + int'(ic_acc) - ir; if (m_ic < 0) m_ic = 0;
            m_dc = m_dc + int'(dc_acc) - dr; if (m_dc < 0) m_dc = 0;
            if (m_owner != 0) begin
                if (mem_ack_i) begin
                    m_last_dc = (m_owner == 2);
                    m_owner   = 0;
                end
            end else if (ic_el && dc_el) m_owner = m_last_dc ? 1 : 2;
            else if (ic_el)              m_owner = 1;
            else if (dc_el)              m_owner = 2;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_in();
        icache_req_i = 0; dcache_req_i = 0; mem_ack_i = 0;
        mem_rtrn_vld_i = 0; mem_rtrn_src_i = 0; drain_i = 0;
        icache_data_i = IC'(rnd()); dcache_data_i = DC'(rnd()); mem_rtrn_data_i = rnd();
    endtask

    task automatic do_reset();
        rst_i = 1; zero_in();
        tick(); tick();
        rst_i = 0;
    endtask

    // Hold one requester with the memory always acking until n accepts are seen.
    task automatic issue(input bit dc, input int n);
        int got = 0, g = 0;
        if (dc) begin dcache_req_i = 1; dcache_data_i = DC'(rnd()); end
        else    begin icache_req_i = 1; icache_data_i = IC'(rnd()); end
        mem_ack_i = 1;
        while (got < n && g < 4 * n + 10) begin
            #2;
            if (dc ? dcache_ack_o : icache_ack_o) got++;
            tick(); g++;
        end
        icache_req_i = 0; dcache_req_i = 0; mem_ack_i = 0;
        chk("issue_count", got, n);
    endtask

    initial begin
        logic [RW-1:0] rd;
        int q[$];
        int n;
        rst_i = 1; zero_in();
        tick();
        chk_en = 1;
        tick();
        rst_i = 0;
        #2;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_ic_cnt", ic_cnt_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_drain_done", drain_done_o, 0);

        // Single I$ request, ack one cycle late, then its return.
        icache_req_i = 1;
        tick(); #2;
        chk("t1_mem_req", mem_req_o, 1);
        chk("t1_mem_src", mem_src_o, 0);
        chk("t1_mem_data", mem_data_o, PW'(icache_data_i));
        tick();
        mem_ack_i = 1; #1;
        chk("t1_ic_ack", icache_ack_o, 1);
        tick();
        icache_req_i = 0; mem_ack_i = 0; #2;
        chk("t1_ic_cnt1", ic_cnt_o, 1);
        tick(); tick();
        rd = rnd();
        mem_rtrn_vld_i = 1; mem_rtrn_src_i = 0; mem_rtrn_data_i = rd; #1;
        chk("t1_ic_rtrn", icache_rtrn_vld_o, 1);
        chk("t1_dc_rtrn", dcache_rtrn_vld_o, 0);
        chk("t1_rtrn_data", rtrn_data_o, rd);
        tick();
        mem_rtrn_vld_i = 0; #2;
        chk("t1_ic_cnt0", ic_cnt_o, 0);

        // Both requesting with memory always acking: strict alternation, I$ first.
        do_reset();
        icache_req_i = 1; dcache_req_i = 1; mem_ack_i = 1;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (mem_req_o) q.push_back(int'(mem_src_o));
            tick();
        end
        chk("t2_grants", q.size() >= 4, 1);
        for (int i = 0; i < 4 && i < q.size(); i++) chk("t2_alt", q[i], i % 2);

        // D$ saturates at the limit; I$ is still served; one return re-opens D$.
        do_reset();
        dcache_req_i = 1; mem_ack_i = 1; n = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (dcache_ack_o) n++;
            tick();
        end
        #2;
        chk("t3_dc_accepts", n, MAXO);
        chk("t3_dc_cnt", dc_cnt_o, MAXO);
        chk("t3_no_req", mem_req_o, 0);
        icache_req_i = 1;
        tick(); #2;
        chk("t3_ic_req", mem_req_o, 1);
        chk("t3_ic_src", mem_src_o, 0);
        chk("t3_ic_ack", icache_ack_o, 1);
        tick();
        icache_req_i = 0; mem_rtrn_vld_i = 1; mem_rtrn_src_i = 1;
        tick();
        mem_rtrn_vld_i = 0;
        tick(); #2;
        chk("t3_dc_resume", mem_req_o, 1);
        chk("t3_dc_src", mem_src_o, 1);
        chk("t3_dc_cnt7", dc_cnt_o, MAXO - 1);

        // Same-cycle accept and return at count 3, then an orphan I$ return.
        do_reset();
        issue(1, 3);
        #2;
        chk("t4_dc_cnt3", dc_cnt_o, 3);
        dcache_req_i = 1;
        tick();
        mem_ack_i = 1; mem_rtrn_vld_i = 1; mem_rtrn_src_i = 1; #1;
        chk("t4_dc_ack", dcache_ack_o, 1);
        chk("t4_dc_rtrn", dcache_rtrn_vld_o, 1);
        tick();
        dcache_req_i = 0; mem_ack_i = 0; mem_rtrn_vld_i = 0; #2;
        chk("t4_dc_cnt_hold", dc_cnt_o, 3);
        mem_rtrn_vld_i = 1; mem_rtrn_src_i = 0;
        tick();
        mem_rtrn_vld_i = 0; #2;
        chk("t4_err", err_o, 1);
        chk("t4_ic_cnt0", ic_cnt_o, 0);
        tick(); tick(); #2;
        chk("t4_err_sticky", err_o, 1);

        // Drain raised mid-grant: the grant completes, nothing new until released.
        do_reset();
        dcache_req_i = 1;
        tick();
        drain_i = 1; icache_req_i = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("t5_grant_held", {mem_req_o, mem_src_o}, 2'b11);
            tick();
        end
        mem_ack_i = 1; #2;
        chk("t5_dc_ack", dcache_ack_o, 1);
        tick();
        dcache_req_i = 0; mem_ack_i = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t5_no_grant", mem_req_o, 0);
            chk("t5_not_done", drain_done_o, 0);
            tick();
        end
        mem_rtrn_vld_i = 1; mem_rtrn_src_i = 1;
        tick();
        mem_rtrn_vld_i = 0; #2;
        chk("t5_dc_cnt0", dc_cnt_o, 0);
        chk("t5_done", drain_done_o, 1);
        drain_i = 0;
        tick(); #2;
        chk("t5_resume", {mem_req_o, mem_src_o}, 2'b10);

        // Reset in the middle of an I$ grant with two in flight and err set.
        do_reset();
        issue(0, 2);
        mem_rtrn_vld_i = 1; mem_rtrn_src_i = 1;
        tick();
        mem_rtrn_vld_i = 0; icache_req_i = 1;
        tick(); #2;
        chk("t6_mem_req", mem_req_o, 1);
        chk("t6_ic_cnt2", ic_cnt_o, 2);
        chk("t6_err", err_o, 1);
        rst_i = 1; icache_req_i = 0;
        tick();
        rst_i = 0; #2;
        chk("t6_mem_req0", mem_req_o, 0);
        chk("t6_ic_cnt0", ic_cnt_o, 0);
        chk("t6_err0", err_o, 0);

        // Random traffic under protocol rules; the model checks every cycle.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (!icache_req_i || e_ic_ack) begin
                icache_req_i = ($urandom % 3 == 0);
                icache_data_i = IC'(rnd());
            end
            if (!dcache_req_i || e_dc_ack) begin
                dcache_req_i = ($urandom % 3 == 0);
                dcache_data_i = DC'(rnd());
            end
            mem_ack_i = $urandom % 2;
            if ($urandom % 60 == 0) drain_i = ~drain_i;
            mem_rtrn_src_i = $urandom % 2;
            mem_rtrn_vld_i = ($urandom % 4 == 0) && (mem_rtrn_src_i ? m_dc > 0 : m_ic > 0);
            mem_rtrn_data_i = rnd();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wt_mem_arbiter.md
# wt_mem_arbiter

Shares one memory-side request channel between the I$ miss path and the D$ miss/write path of the write-through cache subsystem. It sits between the caches and the memory adapter (AXI or L1.5). It arbitrates requests, enforces a per-requester outstanding-transaction limit, routes returns back to the issuing cache, and provides a drain mode used before fence/flush.

## Interface
Parameters:
- `IcWidth`, default 128: I$ request payload width.
- `DcWidth`, default 192: D$ request payload width. The memory payload width is `PW = max(IcWidth, DcWidth)`, with zero-extension at the MSBs.
- `RtrnWidth`, default 256: return payload width.
- `MaxOutstanding`, default 8: per-requester in-flight limit, 1..255. Counter width is `CW = $clog2(MaxOutstanding+1)`.

Ports:
- `clk_i` in 1: clock. Single clock domain.
- `rst_i` in 1: reset. Synchronous, active-high.
- `icache_req_i` in 1: I$ request valid. Held until `icache_ack_o`.
- `icache_data_i` in IcWidth: I$ payload. Stable while `icache_req_i` is high.
- `icache_ack_o` out 1: I$ request accepted by memory.
- `dcache_req_i`, `dcache_data_i`, `dcache_ack_o`: same as the I$ ports, with width DcWidth.
- `mem_req_o` out 1: memory request valid.
- `mem_src_o` out 1: source of the request (0 = I$, 1 = D$).
- `mem_data_o` out PW: request payload.
- `mem_ack_i` in 1: memory accepted the request. Only meaningful while `mem_req_o` is high.
- `mem_rtrn_vld_i` in 1: return valid, single-cycle pulse.
- `mem_rtrn_src_i` in 1: return destination (0 = I$, 1 = D$).
- `mem_rtrn_data_i` in RtrnWidth: return payload.
- `icache_rtrn_vld_o` out 1 and `dcache_rtrn_vld_o` out 1: routed return valids.
- `rtrn_data_o` out RtrnWidth: return payload, shared by both caches.
- `drain_i` in 1: stop issuing new grants. Level-sensitive.
- `drain_done_o` out 1: `drain_i` is high, no grant is active, and both counts are 0.
- `ic_cnt_o` out CW and `dc_cnt_o` out CW: current outstanding counts.
- `err_o` out 1: sticky. Set by a return for a requester whose count is 0.

## Operation
- FSM states: IDLE, GNT_IC, GNT_DC. Reset enters IDLE.
- Eligibility: a requester is eligible when its req is high, its count is below `MaxOutstanding`, and `drain_i` is low.
- Selection in IDLE:
  - If exactly one requester is eligible, go to its GNT state.
  - If both are eligible, use round-robin. The `last` bit records the most recent grant, and the other requester wins. The `last` bit resets to 1, so I$ wins the first tie.
- In a GNT state:
  - `mem_req_o` = 1, `mem_src_o` = 0 for GNT_IC or 1 for GNT_DC.
  - `mem_data_o` = the granted requester's data, passed combinationally.
  - The grant is locked. `drain_i` and the other request do not preempt it.
- Accept:
  - On `mem_ack_i` in a GNT state, drive the matching `*_ack_o` = `mem_ack_i` in the same cycle.
  - Increment that requester's count, update `last`, and return to IDLE.
- Returns:
  - `*_rtrn_vld_o` = `mem_rtrn_vld_i` gated by `mem_rtrn_src_i`.
  - `rtrn_data_o` = `mem_rtrn_data_i`. Combinational, zero latency.
  - Decrement the matching count.
- Simultaneous accept and return to the same requester: the count is unchanged.
- Return to a requester whose count is 0: the count stays 0 (no wrap) and `err_o` is set. Only reset clears `err_o`.
- Count at `MaxOutstanding`: the requester is ineligible, and its req waits. The other requester is unaffected.
- A requester that drops req while granted is a protocol violation and is not supported. The grant holds until `mem_ack_i` regardless.

## Timing
- Reset values:
  - FSM = IDLE, `last` = 1, counts = 0.
  - `err_o` = 0.
  - `mem_req_o` = 0, `mem_src_o` = 0, `mem_data_o` = 0.
  - All `*_ack_o`, `*_rtrn_vld_o` and `drain_done_o` = 0. `rtrn_data_o` follows its input.
- Request latency: req high in cycle N (eligible, FSM in IDLE) gives `mem_req_o` high in cycle N+1. The earliest ack is in N+1.
- Throughput: at most one accept every 2 cycles, because of the IDLE cycle between grants.
- `drain_done_o` is combinational from the registered state and counts.
- Asserting `drain_i` in IDLE blocks a grant in the same cycle.
- Reset mid-grant: `mem_req_o` drops in the cycle after `rst_i` is sampled. In-flight counts are discarded, and the memory side must be reset with the arbiter.

## Test plan
- Single I$ request: ack at cycle 2 → `mem_req_o`=1 at cycle 1, `mem_src_o`=0, `icache_ack_o`=1 at cycle 2, `ic_cnt_o`=1. Return with src 0 at cycle 5 → `icache_rtrn_vld_o`=1, `ic_cnt_o`=0.
- Both requesting continuously, memory always acks → grants alternate I$, D$, I$, D$, with I$ first. `mem_data_o` matches each source, zero-extended.
- D$ with no returns, `MaxOutstanding`=8 → exactly 8 accepts, `dc_cnt_o`=8, no 9th `mem_req_o`. I$ requests still granted. One D$ return → D$ grant resumes.
- Accept and return to D$ in the same cycle at `dc_cnt_o`=3 → `dc_cnt_o` stays 3. Return src 0 with `ic_cnt_o`=0 → `err_o`=1 and sticky, `ic_cnt_o` stays 0.
- `drain_i` raised during GNT_DC with ack delayed 4 cycles → the grant completes. No further grants. `drain_done_o`=1 only after `dc_cnt_o` returns to 0.
- `rst_i` pulsed while GNT_IC with `ic_cnt_o`=2 → next cycle `mem_req_o`=0, counts=0, `err_o`=0, FSM in IDLE.
